// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmitter slice: the transmit FSM state
//   encoding, parity-type constants, fixed line levels for the start and stop
//   bits, and a helper that turns an XOR-reduced byte into the parity bit.
//   No ports. Imported by uart_tx.

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Even parity is the plain XOR reduction of the data.
  // Odd parity is that reduction inverted.
  function automatic logic parityBit(input logic xorReduced, input logic parTyp);
    return (parTyp == PAR_ODD) ? ~xorReduced : xorReduced;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Data latch, right-shift register and bit counter for the UART transmitter.
//   A load captures a new byte into both the latch and the shift register and
//   clears the counter. Each shift moves the next bit into position 0 and
//   counts one more transmitted bit.
//
// Ports
//   CLK      in   bit-rate clock, rising edge
//   RST      in   asynchronous active-low reset
//   i_load   in   capture i_data, restart the bit count
//   i_shift  in   advance to the next data bit
//   i_data   in   byte to capture on load
//   o_bit    out  data bit currently in position 0 of the shift register
//   o_last   out  all DATA_WIDTH bits have been shifted out
//   o_data   out  byte captured at the last load, used for parity

module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_bit,
  output logic                  o_last,
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_count;

  // The counter holds the number of bits already handed to the line.
  // It reaches DATA_WIDTH exactly when the final data bit is on the line,
  // which is when the FSM must leave the DATA state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_data  <= '0;
      r_shift <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_shift <= i_data;
      r_count <= '0;
    end else if (i_shift) begin
      r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
      r_count <= r_count + 1'b1;
    end
  end

  assign o_bit  = r_shift[0];
  assign o_last = (r_count == CNT_W'(DATA_WIDTH));
  assign o_data = r_data;

endmodule

// File: rtl/uart_tx.sv
// uart_tx
//   UART transmitter. Serializes one byte per frame: start bit, DATA_WIDTH
//   data bits LSB first, optional parity bit, one stop bit. One bit per CLK
//   cycle. A byte is accepted on a rising edge with DATA_VALID high while the
//   FSM is in IDLE or STOP, so frames can run back to back with no idle gap.
//
// Ports
//   CLK         in   bit-rate clock, rising edge
//   RST         in   asynchronous active-low reset
//   P_DATA      in   byte to send, sampled on the accept edge
//   DATA_VALID  in   send request
//   PAR_EN      in   1 = append a parity bit, sampled on the accept edge
//   PAR_TYP     in   0 = even, 1 = odd parity, sampled on the accept edge
//   TX_OUT      out  serial line, idle high, registered
//   Busy        out  frame in progress, registered

module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  uart_state_e r_state;
  uart_state_e w_nextState;

  logic r_parEn;
  logic r_parTyp;
  logic r_txOut;
  logic r_busy;

  logic                  w_nextTx;
  logic                  w_nextBusy;
  logic                  w_load;
  logic                  w_shift;
  logic                  w_bit;
  logic                  w_last;
  logic                  w_parity;
  logic [DATA_WIDTH-1:0] w_data;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .CLK    (CLK),
    .RST    (RST),
    .i_load (w_load),
    .i_shift(w_shift),
    .i_data (P_DATA),
    .o_bit  (w_bit),
    .o_last (w_last),
    .o_data (w_data)
  );

  assign w_parity = parityBit(^w_data, r_parTyp);

  // Next-state and next-line logic. TX_OUT and Busy are registered, so the
  // value computed here is the level the line takes for the state being
  // entered. Leaving START shifts out data bit 0 and each DATA cycle that is
  // not the last shifts out the following bit.
  always_comb begin
    w_nextState = r_state;
    w_nextTx    = STOP_BIT;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        if (DATA_VALID) begin
          w_nextState = START;
          w_nextTx    = START_BIT;
          w_load      = 1'b1;
        end
      end
      START: begin
        w_nextState = DATA;
        w_nextTx    = w_bit;
        w_shift     = 1'b1;
      end
      DATA: begin
        if (w_last) begin
          if (r_parEn) begin
            w_nextState = PARITY;
            w_nextTx    = w_parity;
          end else begin
            w_nextState = STOP;
            w_nextTx    = STOP_BIT;
          end
        end else begin
          w_nextState = DATA;
          w_nextTx    = w_bit;
          w_shift     = 1'b1;
        end
      end
      PARITY: begin
        w_nextState = STOP;
        w_nextTx    = STOP_BIT;
      end
      STOP: begin
        // Accepting here chains the next start bit directly after the stop bit.
        if (DATA_VALID) begin
          w_nextState = START;
          w_nextTx    = START_BIT;
          w_load      = 1'b1;
        end else begin
          w_nextState = IDLE;
          w_nextTx    = STOP_BIT;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextTx    = STOP_BIT;
      end
    endcase
  end

  assign w_nextBusy = (w_nextState != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= IDLE;
      r_parEn  <= 1'b0;
      r_parTyp <= PAR_EVEN;
      r_txOut  <= STOP_BIT;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_txOut <= w_nextTx;
      r_busy  <= w_nextBusy;
      if (w_load) begin
        r_parEn  <= PAR_EN;
        r_parTyp <= PAR_TYP;
      end
    end
  end

  assign TX_OUT = r_txOut;
  assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
//   Self-checking bench for uart_tx. Expected line levels come from a
//   frame builder that lists the bits of a frame straight from the framing
//   rules (start 0, data LSB first, parity from the count of ones, stop 1).
//   Outputs are sampled on the falling edge, inputs change on the falling edge.

module tb_uart_tx;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       pt;
  } frame_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int testCount = 0;
  int failCount = 0;

  bit     expLine[$];
  frame_t frameQ[$];

  uart_tx #(
    .DATA_WIDTH(8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  // Reference model: the full sequence of line levels for one frame.
  function automatic void buildFrame(input logic [7:0] d, input logic pe, input logic pt);
    bit oddOnes;
    expLine.delete();
    expLine.push_back(1'b0);
    for (int i = 0; i < 8; i++) expLine.push_back(d[i]);
    oddOnes = (($countones(d) % 2) == 1);
    if (pe) expLine.push_back(oddOnes ^ pt);
    expLine.push_back(1'b1);
  endfunction

  task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic pt, input logic v);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    DATA_VALID = v;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    applyStimulus(8'hFF, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge CLK);
    testCount++;
    if (TX_OUT !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_tx: TX_OUT got %b want 1", TX_OUT);
    end
    testCount++;
    if (Busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_busy: Busy got %b want 0", Busy);
    end
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    testCount++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL idle_after_reset: TX_OUT/Busy got %b/%b want 1/0", TX_OUT, Busy);
    end
  endtask

  // One isolated frame; inputs are scrambled after the accept edge to show
  // the frame only uses what was latched.
  task automatic test_frame(input logic [7:0] d, input logic pe, input logic pt);
    applyStimulus(d, pe, pt, 1'b1);
    buildFrame(d, pe, pt);
    @(posedge CLK);
    for (int j = 0; j < expLine.size(); j++) begin
      @(negedge CLK);
      if (j == 0) applyStimulus(8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      testCount++;
      if (TX_OUT !== expLine[j]) begin
        failCount++;
        $display("[TB] FAIL frame_%02h_bit%0d: TX_OUT got %b want %b", d, j, TX_OUT, expLine[j]);
      end
      testCount++;
      if (Busy !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL frame_%02h_busy%0d: Busy got %b want 1", d, j, Busy);
      end
    end
    @(negedge CLK);
    testCount++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL frame_%02h_end: TX_OUT/Busy got %b/%b want 1/0", d, TX_OUT, Busy);
    end
  endtask

  // Plays every frame in frameQ back to back, offering the next one during
  // the stop cycle. With hold set, DATA_VALID never drops and P_DATA keeps
  // changing inside frames.
  task automatic test_back_to_back(input bit hold);
    frame_t cur;
    frame_t nxt;
    int     n;
    n   = frameQ.size();
    cur = frameQ.pop_front();
    applyStimulus(cur.d, cur.pe, cur.pt, 1'b1);
    @(posedge CLK);
    for (int f = 0; f < n; f++) begin
      buildFrame(cur.d, cur.pe, cur.pt);
      for (int j = 0; j < expLine.size(); j++) begin
        @(negedge CLK);
        testCount++;
        if (TX_OUT !== expLine[j]) begin
          failCount++;
          $display("[TB] FAIL b2b_f%0d_%02h_bit%0d: TX_OUT got %b want %b", f, cur.d, j, TX_OUT, expLine[j]);
        end
        testCount++;
        if (Busy !== 1'b1) begin
          failCount++;
          $display("[TB] FAIL b2b_f%0d_busy%0d: Busy got %b want 1", f, j, Busy);
        end
        if (j == expLine.size() - 1) begin
          if (f < n - 1) begin
            nxt = frameQ.pop_front();
            applyStimulus(nxt.d, nxt.pe, nxt.pt, 1'b1);
          end else begin
            applyStimulus(8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
          end
        end else begin
          applyStimulus(8'($urandom), 1'($urandom), 1'($urandom), hold);
        end
      end
      cur = nxt;
    end
    @(negedge CLK);
    testCount++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_end: TX_OUT/Busy got %b/%b want 1/0", TX_OUT, Busy);
    end
  endtask

  // DATA_VALID pulsed while data bits are on the line must be ignored.
  task automatic test_ignore();
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b1);
    buildFrame(8'h55, 1'b0, 1'b0);
    @(posedge CLK);
    for (int j = 0; j < expLine.size(); j++) begin
      @(negedge CLK);
      if (j == 0) DATA_VALID = 1'b0;
      if (j == 3) applyStimulus(8'hFF, 1'b1, 1'b1, 1'b1);
      if (j == 5) DATA_VALID = 1'b0;
      testCount++;
      if (TX_OUT !== expLine[j] || Busy !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL ignore_bit%0d: TX_OUT/Busy got %b/%b want %b/1", j, TX_OUT, Busy, expLine[j]);
      end
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge CLK);
      testCount++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL ignore_idle%0d: TX_OUT/Busy got %b/%b want 1/0", j, TX_OUT, Busy);
      end
    end
  endtask

  // Reset during data bit 3 must drop the frame immediately.
  task automatic test_reset_midframe();
    applyStimulus(8'hA2, 1'b1, 1'b0, 1'b1);
    buildFrame(8'hA2, 1'b1, 1'b0);
    @(posedge CLK);
    for (int j = 0; j <= 4; j++) begin
      @(negedge CLK);
      if (j == 0) DATA_VALID = 1'b0;
      testCount++;
      if (TX_OUT !== expLine[j]) begin
        failCount++;
        $display("[TB] FAIL pre_reset_bit%0d: TX_OUT got %b want %b", j, TX_OUT, expLine[j]);
      end
    end
    #2 RST = 1'b0;
    #1;
    testCount++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL async_reset: TX_OUT/Busy got %b/%b want 1/0", TX_OUT, Busy);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    testCount++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL post_reset_idle: TX_OUT/Busy got %b/%b want 1/0", TX_OUT, Busy);
    end
    test_frame(8'hA2, 1'b1, 1'b0);
  endtask

  initial begin
    frame_t fr;
    test_reset();
    test_frame(8'hA2, 1'b1, 1'b0);
    test_frame(8'h66, 1'b1, 1'b0);
    test_frame(8'h66, 1'b0, 1'b0);
    frameQ.delete();
    frameQ.push_back(frame_t'{d: 8'hEB, pe: 1'b1, pt: 1'b1});
    frameQ.push_back(frame_t'{d: 8'h01, pe: 1'b0, pt: 1'b0});
    test_back_to_back(1'b0);
    test_ignore();
    test_reset_midframe();
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      test_frame(8'($urandom), 1'($urandom), 1'($urandom));
    end
    frameQ.delete();
    for (int r = 0; r < 6; r++) begin
      fr.d  = 8'($urandom);
      fr.pe = 1'($urandom);
      fr.pt = 1'($urandom);
      frameQ.push_back(fr);
    end
    test_back_to_back(1'b1);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
